// File: rtl/mult_hilo_seq_if.sv
// Request, HI/LO and CompMult handshake bundle for the multiply sequencer.
// master = execute stage plus multiplier side; slave = the sequencer itself.
interface mult_hilo_seq_if;
    logic        op_valid;
    logic        op_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_busy;
    logic        mul_load;
    logic        mul_run;
    logic [31:0] mul_multiplicand;
    logic [31:0] mul_multiplier;
    logic        mul_ready;
    logic [63:0] mul_product;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        timeout;

    modport master (
        output op_valid, op_signed, op_a, op_b, mul_ready, mul_product,
               hi_we, lo_we, wdata,
        input  op_busy, mul_load, mul_run, mul_multiplicand, mul_multiplier,
               hi, lo, done, timeout
    );

    modport slave (
        input  op_valid, op_signed, op_a, op_b, mul_ready, mul_product,
               hi_we, lo_we, wdata,
        output op_busy, mul_load, mul_run, mul_multiplicand, mul_multiplier,
               hi, lo, done, timeout
    );
endinterface

// File: rtl/mult_hilo_seq.sv
// Multiply sequencer driving CompMult load/run, sign fix-up, and HI/LO register file.
// Latency: accept-to-done 5+k cycles (k = WAIT cycles until ready), WAIT_MAX+3 on timeout.
// Backpressure: op_valid is only taken in IDLE; requests arriving while busy are dropped.
module mult_hilo_seq #(
    parameter int WAIT_MAX = 100
) (
    input  logic            clk,
    input  logic            reset,
    mult_hilo_seq_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIXUP = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    logic [2:0]    state;
    logic [31:0]   mcand_q;
    logic [31:0]   mplier_q;
    logic          neg_q;
    logic [63:0]   prod_q;
    logic [CW-1:0] wait_cnt;
    logic          timeout_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Handshake outputs decode straight from state so nothing combinational reaches them from inputs.
    assign bus.op_busy          = (state != S_IDLE);
    assign bus.mul_load         = (state == S_LOAD);
    assign bus.mul_run          = (state == S_RUN);
    assign bus.done             = (state == S_DONE);
    assign bus.timeout          = timeout_q;
    assign bus.mul_multiplicand = mcand_q;
    assign bus.mul_multiplier   = mplier_q;
    assign bus.hi               = hi_q;
    assign bus.lo               = lo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            prod_q    <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        mcand_q   <= bus.op_signed ? mag32(bus.op_a) : bus.op_a;
                        mplier_q  <= bus.op_signed ? mag32(bus.op_b) : bus.op_b;
                        neg_q     <= bus.op_signed & (bus.op_a[31] ^ bus.op_b[31]);
                        timeout_q <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD:  state <= S_RUN;
                S_RUN: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Ready wins over the limit, so a result on the final WAIT cycle still commits.
                    if (bus.mul_ready) begin
                        prod_q <= bus.mul_product;
                        state  <= S_FIXUP;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_FIXUP: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // The multiply commit outranks MTHI/MTLO on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == S_FIXUP) begin
            {hi_q, lo_q} <= neg_q ? (~prod_q + 64'd1) : prod_q;
        end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_mult_hilo_seq.sv
module tb_mult_hilo_seq;
    localparam int WM = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_hilo_seq_if ifc ();

    mult_hilo_seq #(.WAIT_MAX(WM)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int cyc_acc = 0;
    int cur_lat = 0;
    bit no_ready = 1'b0;
    int rem = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CompMult: load clears ready, run starts a countdown of cur_lat extra cycles.
    always @(posedge clk) begin
        if (!rst_n) begin
            ifc.mul_ready   <= 1'b0;
            ifc.mul_product <= '0;
            rem             <= 0;
        end else if (ifc.mul_load) begin
            ifc.mul_ready   <= 1'b0;
            ifc.mul_product <= {32'd0, ifc.mul_multiplicand} * {32'd0, ifc.mul_multiplier};
            rem             <= 0;
        end else if (ifc.mul_run) begin
            if (!no_ready) begin
                if (cur_lat == 0) ifc.mul_ready <= 1'b1;
                else rem <= cur_lat;
            end
        end else if (rem != 0) begin
            rem <= rem - 1;
            if (rem == 1) ifc.mul_ready <= 1'b1;
        end
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a, b, mc, mp, ehi, elo;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x;
        if (sgn) x = longint'($signed(a)) * longint'($signed(b));
        else x = longint'({32'd0, a}) * longint'({32'd0, b});
        return x;
    endfunction

    function automatic logic [31:0] ref_mag(input logic sgn, input logic [31:0] v);
        longint x;
        x = sgn ? longint'($signed(v)) : longint'({32'd0, v});
        if (x < 0) x = -x;
        return x[31:0];
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the LOAD cycle.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int lat,
                            input logic [31:0] emc, input logic [31:0] emp);
        cur_lat       = lat;
        ifc.op_valid  = 1'b1;
        ifc.op_signed = sgn;
        ifc.op_a      = a;
        ifc.op_b      = b;
        @(posedge clk);
        @(negedge clk);
        ifc.op_valid = 1'b0;
        cyc_acc = cyc;
        check("load pulse", 64'(ifc.mul_load), 64'd1);
        check("busy in load", 64'(ifc.op_busy), 64'd1);
        check("multiplicand", 64'(ifc.mul_multiplicand), 64'(emc));
        check("multiplier", 64'(ifc.mul_multiplier), 64'(emp));
    endtask

    // Waits for done, checks latency/result, ends at the negedge of the following IDLE cycle.
    task automatic finish_op(input logic [63:0] exp_hilo, input int exp_lat, input logic exp_to);
        bit seen = 1'b0;
        bit busy_bad = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ifc.done) begin
                seen = 1'b1;
                ifc.op_valid = 1'b0;
                break;
            end
            if (!ifc.op_busy) busy_bad = 1'b1;
        end
        check("done seen", 64'(seen), 64'd1);
        if (seen) begin
            check("latency", 64'(cyc - cyc_acc + 1), 64'(exp_lat));
            check("hi", 64'(ifc.hi), 64'(exp_hilo[63:32]));
            check("lo", 64'(ifc.lo), 64'(exp_hilo[31:0]));
            check("timeout flag", 64'(ifc.timeout), 64'(exp_to));
            check("busy in done", 64'(ifc.op_busy), 64'd1);
        end
        check("busy held", 64'(busy_bad), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("idle after done", 64'(ifc.op_busy | ifc.done), 64'd0);
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int lat);
        logic [63:0] p;
        p = ref_mul(sgn, a, b);
        start_op(sgn, a, b, lat, ref_mag(sgn, a), ref_mag(sgn, b));
        finish_op(p, 5 + lat, 1'b0);
        {exp_hi, exp_lo} = p;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [63:0] p;
        ifc.op_valid = 1'b0; ifc.op_signed = 1'b0; ifc.op_a = '0; ifc.op_b = '0;
        ifc.hi_we = 1'b0; ifc.lo_we = 1'b0; ifc.wdata = '0;

        tbl[0] = '{1'b0, 32'd15,        32'd19,        32'd15,        32'd19,        32'h0000_0000, 32'h0000_011D};
        tbl[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'd3,         32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd1,         32'h0000_0000, 32'h0000_0001};
        tbl[5] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'h0000_0002};
        tbl[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000};
        tbl[7] = '{1'b0, 32'd2,         32'd3,         32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006};

        repeat (3) @(negedge clk);
        check("rst hi", 64'(ifc.hi), 64'd0);
        check("rst lo", 64'(ifc.lo), 64'd0);
        check("rst strobes", 64'({ifc.op_busy, ifc.mul_load, ifc.mul_run, ifc.done, ifc.timeout}), 64'd0);
        check("rst operands", {ifc.mul_multiplicand, ifc.mul_multiplier}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors; latency sweeps 0..WM-1 so the last-WAIT-cycle ready is covered.
        for (int i = 0; i < 8; i++) begin
            start_op(tbl[i].sgn, tbl[i].a, tbl[i].b, i % WM, tbl[i].mc, tbl[i].mp);
            finish_op({tbl[i].ehi, tbl[i].elo}, 5 + (i % WM), 1'b0);
            {exp_hi, exp_lo} = {tbl[i].ehi, tbl[i].elo};
        end

        // MTHI in IDLE.
        ifc.hi_we = 1'b1; ifc.wdata = 32'h1234_5678;
        @(negedge clk);
        ifc.hi_we = 1'b0;
        exp_hi = 32'h1234_5678;
        check("mthi idle", 64'(ifc.hi), 64'(exp_hi));
        check("mthi lo kept", 64'(ifc.lo), 64'(exp_lo));

        // MTHI on the same edge as an accept: both take effect.
        ifc.hi_we = 1'b1; ifc.wdata = 32'h0BAD_F00D;
        start_op(1'b0, 32'd9, 32'd9, 1, 32'd9, 32'd9);
        ifc.hi_we = 1'b0;
        check("mthi with accept", 64'(ifc.hi), 64'h0BAD_F00D);
        finish_op(64'd81, 6, 1'b0);
        {exp_hi, exp_lo} = 64'd81;

        // MTLO during WAIT, later overwritten by the product.
        start_op(1'b0, 32'd1000, 32'd7, 4, 32'd1000, 32'd7);
        @(negedge clk);
        @(negedge clk);
        ifc.lo_we = 1'b1; ifc.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ifc.lo_we = 1'b0;
        check("mtlo in wait", 64'(ifc.lo), 64'hDEAD_BEEF);
        finish_op(64'd7000, 9, 1'b0);
        {exp_hi, exp_lo} = 64'd7000;

        // Timeout: multiplier never raises ready.
        no_ready = 1'b1;
        start_op(1'b1, 32'hFFFF_FFF0, 32'd3, 0, 32'd16, 32'd3);
        finish_op({exp_hi, exp_lo}, WM + 3, 1'b1);
        check("timeout held", 64'(ifc.timeout), 64'd1);
        no_ready = 1'b0;
        start_op(1'b0, 32'd4, 32'd5, 2, 32'd4, 32'd5);
        check("timeout cleared", 64'(ifc.timeout), 64'd0);
        finish_op(64'd20, 7, 1'b0);
        {exp_hi, exp_lo} = 64'd20;

        // op_valid held while busy must be ignored.
        start_op(1'b0, 32'd5, 32'd6, 2, 32'd5, 32'd6);
        ifc.op_valid = 1'b1; ifc.op_a = 32'd77; ifc.op_b = 32'd77;
        finish_op(64'd30, 7, 1'b0);
        {exp_hi, exp_lo} = 64'd30;
        dones = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (ifc.done) dones++;
        end
        check("no second done", 64'(dones), 64'd0);

        // Randomized traffic, back-to-back, against the arithmetic model.
        for (int r = 0; r < 30; r++) begin
            logic sg;
            logic [31:0] ra, rb;
            sg = 1'($urandom_range(0, 1));
            ra = pick_operand();
            rb = pick_operand();
            run_op(sg, ra, rb, $urandom_range(0, WM - 1));
        end

        // Reset during WAIT clears everything with no done.
        ifc.hi_we = 1'b1; ifc.wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        ifc.hi_we = 1'b0;
        start_op(1'b0, 32'd11, 32'd13, 6, 32'd11, 32'd13);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst hi/lo", {ifc.hi, ifc.lo}, 64'd0);
        check("arst strobes", 64'({ifc.op_busy, ifc.mul_load, ifc.mul_run, ifc.done, ifc.timeout}), 64'd0);
        check("arst operands", {ifc.mul_multiplicand, ifc.mul_multiplier}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        {exp_hi, exp_lo} = 64'd0;
        @(negedge clk);
        p = ref_mul(1'b0, 32'd2, 32'd3);
        run_op(1'b0, 32'd2, 32'd3, 1);
        check("post-reset lo", 64'(ifc.lo), p & 64'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mult_hilo_seq.md
# mult_hilo_seq

Multiply sequencer and HI/LO register file for the MIPS datapath. It sits directly upstream of the iterative `CompMult` multiplier. It accepts MULT/MULTU requests from the execute stage and drives the multiplier's load/run handshake. It waits for `ready`, applies the sign fix-up, and commits the 64-bit result into HI/LO for MFHI/MFLO. MTHI/MTLO writes are also handled here.

## Interface
- `WAIT_MAX`, default 100: maximum number of WAIT cycles before the request is aborted with `timeout`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
- `op_valid`  in  1  multiply request; accepted only in IDLE.
- `op_signed`  in  1  1 = MULT (two's complement), 0 = MULTU.
- `op_a`  in  32  first operand (rs).
- `op_b`  in  32  second operand (rt).
- `op_busy`  out  1  1 in every state except IDLE.
- `mul_load`  out  1  drives CompMult `reset`; one-cycle pulse that loads the operands.
- `mul_run`  out  1  drives CompMult `run`; one-cycle pulse.
- `mul_multiplicand`  out  32  to CompMult `Multiplicand_in`.
- `mul_multiplier`  out  32  to CompMult `Multiplier_in`.
- `mul_ready`  in  1  from CompMult `ready`.
- `mul_product`  in  64  from CompMult `Product_out`.
- `hi_we`, `lo_we`  in  1  MTHI / MTLO strobes.
- `wdata`  in  32  MTHI/MTLO data.
- `hi`, `lo`  out  32  architectural HI/LO.
- `done`  out  1  one-cycle pulse at the end of every accepted request.
- `timeout`  out  1  set on abort; held until the next accepted request.

## Operation
- States: IDLE, LOAD, RUN, WAIT, FIXUP, DONE.
- IDLE: on an edge with `op_valid`=1, latch the operands, go to LOAD and clear `timeout`.
  - Operand latch: magnitudes |op_a|, |op_b| when `op_signed`=1, otherwise raw values.
  - `neg` = op_a[31]^op_b[31] when signed, else 0.
- LOAD: `mul_load`=1; `mul_multiplicand`/`mul_multiplier` hold the latched values from LOAD until IDLE. Next state RUN.
- RUN: `mul_run`=1; next state WAIT; the wait counter is cleared.
- WAIT: `mul_ready` is sampled only in this state.
  - `mul_ready`=1: capture `mul_product`, go to FIXUP.
  - Otherwise the counter increments.
  - Counter == WAIT_MAX-1 with no ready: set `timeout`, go to DONE. HI/LO are not written.
- FIXUP: hi:lo <= neg ? (~P + 1) mod 2^64 : P; next state DONE.
  - Negation is a full 64-bit two's complement.
  - |0x80000000| = 0x80000000 treated as unsigned, which is correct.
- DONE: `done`=1; next state IDLE.
- `op_valid` in any non-IDLE state is ignored; it is not queued.
- MTHI/MTLO: `hi_we`/`lo_we` write `wdata` into HI/LO on the edge in any state.
  - The same-edge FIXUP commit takes priority over both.
  - A write during LOAD..WAIT is later overwritten by the multiply result, matching MIPS undefined-HI/LO semantics.
  - `hi_we` and `lo_we` together write both registers.
- `op_valid` together with `hi_we` in IDLE: the write is applied and the request is accepted.
- Reset values: state IDLE.
  - `hi`, `lo`, `mul_multiplicand`, `mul_multiplier`, latched product and counter = 0.
  - `op_busy`, `mul_load`, `mul_run`, `done`, `timeout` = 0.
- Reset asserted mid-operation aborts with no `done`. HI/LO return to 0.

## Timing
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- Accept edge at cycle T:
  - LOAD during T+1, RUN during T+2.
  - WAIT starts T+3; ready seen in WAIT cycle T+3+k.
  - FIXUP at T+4+k; `hi`/`lo` are valid from T+5+k.
  - `done` is high during T+5+k; IDLE at T+6+k.
- Total accept-to-`done` latency = 5 + k cycles. A back-to-back request can be accepted at the T+6+k edge.
- Timeout path: `done` and `timeout` are high WAIT_MAX+3 cycles after accept.
- A stale `mul_ready`=1 from a previous result is not seen because `mul_load` clears it in CompMult before WAIT.

## Test plan
- MULTU 15 × 19 with a CompMult instance → `done` pulse; hi=0x00000000, lo=0x0000011D; `op_busy` high from LOAD through DONE.
- MULT −3 × 7 (0xFFFFFFFD, 0x00000007) → `mul_multiplicand`=3, `mul_multiplier`=7; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0; MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Behavioural multiplier model holding `mul_ready`=0 with WAIT_MAX=8 → `done` and `timeout` high exactly 11 cycles after accept; hi/lo unchanged; the next accept clears `timeout`.
- MTHI 0x12345678 in IDLE → hi updates next edge. MTLO during WAIT then a result commit → lo ends with the product. `op_valid` while busy → no second `done`.
- `reset`=0 during WAIT → all outputs 0 immediately. After release, a fresh MULTU 2 × 3 yields lo=6.
